execute_alu_muldiv: RTL and testbench

EXECUTE_ALU_MULDIV -- requirements
Module: execute_alu_muldiv

---
 rtl/alu_pkg.sv | 29 ++
 rtl/muldiv_iter.sv | 83 ++++++++
 rtl/execute_alu_muldiv.sv | 126 ++++++++++++
 tb/tb_execute_alu_muldiv.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Operation codes and execute-stage state encoding shared with the ALU control stage.
// The MUL/DIV codes only map to real operations when ALU_MULDIV_EN is defined.
package alu_pkg;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_XOR = 4'b0100;
    localparam logic [3:0] OP_MUL = 4'b0101;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_SLL = 4'b1000;
    localparam logic [3:0] OP_SRL = 4'b1001;
    localparam logic [3:0] OP_SRA = 4'b1010;
    localparam logic [3:0] OP_DIV = 4'b1011;
    localparam logic [3:0] OP_NOR = 4'b1100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } alu_state_t;

    function automatic logic is_muldiv(input logic [3:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iterative signed multiply (shift-add) and restoring divide on operand magnitudes.
// One iteration per cycle while run is high; result is valid in the cycle where last is high.
module muldiv_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_div,
    input  logic             run,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             last,
    output logic [WIDTH-1:0] result
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

    logic [CW-1:0]    count_reg;
    logic             div_reg;
    logic             neg_reg;
    logic             div_zero_reg;
    // mul: multiplicand / multiplier / product; div: dividend->quotient / divisor / remainder
    logic [WIDTH-1:0] opa_reg, opb_reg, acc_reg;
    logic [WIDTH-1:0] opa_next, opb_next, acc_next;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [WIDTH:0]   rem_shift;
    logic             rem_ge;
    logic [WIDTH-1:0] mag_next;
    logic [WIDTH-1:0] signed_next;

    assign mag_a = a[WIDTH-1] ? -a : a;
    assign mag_b = b[WIDTH-1] ? -b : b;

    always_comb begin
        rem_shift = {acc_reg, opa_reg[WIDTH-1]};
        rem_ge    = (rem_shift >= {1'b0, opb_reg});
        if (div_reg) begin
            acc_next = rem_ge ? WIDTH'(rem_shift - {1'b0, opb_reg}) : rem_shift[WIDTH-1:0];
            opa_next = {opa_reg[WIDTH-2:0], rem_ge};
            opb_next = opb_reg;
        end else begin
            acc_next = opb_reg[0] ? (acc_reg + opa_reg) : acc_reg;
            opa_next = opa_reg << 1;
            opb_next = opb_reg >> 1;
        end
    end

    // Final value is taken from the last iteration's next-state so it can be registered on that edge.
    assign mag_next    = div_reg ? opa_next : acc_next;
    assign signed_next = neg_reg ? -mag_next : mag_next;
    assign result      = (div_reg && div_zero_reg) ? '1 : signed_next;
    assign last        = run && (count_reg == LAST_COUNT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg    <= '0;
            div_reg      <= 1'b0;
            neg_reg      <= 1'b0;
            div_zero_reg <= 1'b0;
            opa_reg      <= '0;
            opb_reg      <= '0;
            acc_reg      <= '0;
        end else if (start) begin
            count_reg    <= '0;
            div_reg      <= is_div;
            neg_reg      <= a[WIDTH-1] ^ b[WIDTH-1];
            div_zero_reg <= (b == '0);
            opa_reg      <= mag_a;
            opb_reg      <= mag_b;
            acc_reg      <= '0;
        end else if (run) begin
            count_reg <= count_reg + CW'(1);
            opa_reg   <= opa_next;
            opb_reg   <= opb_next;
            acc_reg   <= acc_next;
        end
    end

endmodule

// File: rtl/execute_alu_muldiv.sv
// Execute-stage ALU: single-cycle logic/arith/shift ops, plus iterative mul/div
// when ALU_MULDIV_EN is defined (otherwise 0101/1011 behave as undefined codes).
module execute_alu_muldiv
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             In_Valid,
    input  logic [3:0]       ALU_Control,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [4:0]       Shamt,
    input  logic             Flush,
    output logic             Busy,
    output logic             Out_Valid,
    output logic [WIDTH-1:0] ALUResult,
    output logic             Zero
);

    alu_state_t       state_reg;
    logic             out_valid_reg;
    logic [WIDTH-1:0] result_reg;
    logic             zero_reg;
    logic [WIDTH-1:0] alu_next;

    always_comb begin
        alu_next = '0;
        case (ALU_Control)
            OP_AND: alu_next = A & B;
            OP_OR:  alu_next = A | B;
            OP_ADD: alu_next = A + B;
            OP_SUB: alu_next = A - B;
            OP_NOR: alu_next = ~(A | B);
            OP_XOR: alu_next = A ^ B;
            OP_SLT: alu_next = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
            OP_SLL: alu_next = B << Shamt;
            OP_SRL: alu_next = B >> Shamt;
            OP_SRA: alu_next = $signed(B) >>> Shamt;
            default: alu_next = '0;
        endcase
    end

`ifdef ALU_MULDIV_EN
    logic             busy_reg;
    logic             md_start;
    logic             md_last;
    logic [WIDTH-1:0] md_result;

    assign Busy     = busy_reg;
    assign md_start = In_Valid && !busy_reg && !Flush && is_muldiv(ALU_Control);

    muldiv_iter #(
        .WIDTH (WIDTH)
    ) u_muldiv_iter (
        .clk    (Clk),
        .rst    (Reset),
        .start  (md_start),
        .is_div (ALU_Control == OP_DIV),
        .run    (busy_reg),
        .a      (A),
        .b      (B),
        .last   (md_last),
        .result (md_result)
    );
`else
    assign Busy = 1'b0;
`endif

    // DONE has Busy low and accepts like IDLE, giving back-to-back issue after mul/div.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_reg     <= ST_IDLE;
            out_valid_reg <= 1'b0;
            result_reg    <= '0;
            zero_reg      <= 1'b1;
`ifdef ALU_MULDIV_EN
            busy_reg      <= 1'b0;
`endif
        end else begin
            out_valid_reg <= 1'b0;
            if (Flush) begin
                state_reg <= ST_IDLE;
`ifdef ALU_MULDIV_EN
                busy_reg  <= 1'b0;
`endif
            end else begin
                case (state_reg)
`ifdef ALU_MULDIV_EN
                    ST_MUL, ST_DIV: begin
                        if (md_last) begin
                            state_reg     <= ST_DONE;
                            busy_reg      <= 1'b0;
                            result_reg    <= md_result;
                            zero_reg      <= (md_result == '0);
                            out_valid_reg <= 1'b1;
                        end
                    end
`endif
                    default: begin
                        state_reg <= ST_IDLE;
                        if (In_Valid) begin
`ifdef ALU_MULDIV_EN
                            if (md_start) begin
                                state_reg <= (ALU_Control == OP_DIV) ? ST_DIV : ST_MUL;
                                busy_reg  <= 1'b1;
                            end else
`endif
                            begin
                                result_reg    <= alu_next;
                                zero_reg      <= (alu_next == '0);
                                out_valid_reg <= 1'b1;
                            end
                        end
                    end
                endcase
            end
        end
    end

    assign Out_Valid = out_valid_reg;
    assign ALUResult = result_reg;
    assign Zero      = zero_reg;

endmodule

// File: tb/tb_execute_alu_muldiv.sv
// Self-checking bench for execute_alu_muldiv: directed table, random ops against an
// arithmetic reference model, and mul/div sequences when ALU_MULDIV_EN is defined.
`timescale 1ns/1ps
module tb_execute_alu_muldiv;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        In_Valid;
    logic [3:0]  ALU_Control;
    logic [31:0] A;
    logic [31:0] B;
    logic [4:0]  Shamt;
    logic        Flush;
    logic        Busy;
    logic        Out_Valid;
    logic [31:0] ALUResult;
    logic        Zero;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] last_res;

    always #5 Clk = ~Clk;

    execute_alu_muldiv #(.WIDTH(32)) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .In_Valid    (In_Valid),
        .ALU_Control (ALU_Control),
        .A           (A),
        .B           (B),
        .Shamt       (Shamt),
        .Flush       (Flush),
        .Busy        (Busy),
        .Out_Valid   (Out_Valid),
        .ALUResult   (ALUResult),
        .Zero        (Zero)
    );

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  sh;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [13];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, req);
        end
    endtask

    // Reference model from the arithmetic definition of each operation.
    function automatic logic [31:0] ref_single(input logic [3:0] op, input logic [31:0] a,
                                               input logic [31:0] b, input logic [4:0] sh);
        longint sa = longint'(int'(a));
        longint sb = longint'(int'(b));
        longint ua = longint'(a);
        longint ub = longint'(b);
        longint p2 = longint'(1) << sh;
        longint q;
        case (op)
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b0010: return 32'(ua + ub);
            4'b0110: return 32'(ua - ub);
            4'b1100: return ~(a | b);
            4'b0100: return a ^ b;
            4'b0111: return (sa < sb) ? 32'd1 : 32'd0;
            4'b1000: return 32'(ub * p2);
            4'b1001: return 32'(ub / p2);
            4'b1010: begin
                q = sb / p2;
                if (sb < 0 && (sb % p2) != 0) q = q - 1;
                return 32'(q);
            end
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] ref_long(input bit is_div, input logic [31:0] a, input logic [31:0] b);
        longint sa = longint'(int'(a));
        longint sb = longint'(int'(b));
        if (!is_div) return 32'(sa * sb);
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return 32'(sa / sb);
    endfunction

    task automatic apply_single(input string nm, input logic [3:0] op, input logic [31:0] a,
                                input logic [31:0] b, input logic [4:0] sh, input logic [31:0] exp);
        ALU_Control = op; A = a; B = b; Shamt = sh; In_Valid = 1'b1;
        @(posedge Clk); #1;
        In_Valid = 1'b0;
        check({nm, ".valid"}, 32'(Out_Valid), 32'd1);
        check(nm, ALUResult, exp);
        check({nm, ".zero"}, 32'(Zero), 32'(exp == 32'd0));
        last_res = exp;
        $display("%-10s op=%b a=%h b=%h sh=%0d -> %h (expect %h)", nm, op, a, b, sh, ALUResult, exp);
    endtask

    task automatic run_long(input string nm, input bit is_div, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] exp, input bit poke);
        int n = 0;
        int early = 0;
        int moved = 0;
        ALU_Control = is_div ? 4'b1011 : 4'b0101; A = a; B = b; Shamt = 5'd0; In_Valid = 1'b1;
        @(posedge Clk); #1;
        In_Valid = poke;
        if (poke) begin ALU_Control = 4'b0010; A = 32'd1; B = 32'd1; end
        while (Busy && n < 100) begin
            if (Out_Valid) early++;
            if (ALUResult !== last_res) moved++;
            n++;
            @(posedge Clk); #1;
        end
        In_Valid = 1'b0;
        check({nm, ".busy_cycles"}, 32'(n), 32'd32);
        check({nm, ".early_valid"}, 32'(early), 32'd0);
        check({nm, ".held"}, 32'(moved), 32'd0);
        check({nm, ".valid"}, 32'(Out_Valid), 32'd1);
        check(nm, ALUResult, exp);
        check({nm, ".zero"}, 32'(Zero), 32'(exp == 32'd0));
        last_res = exp;
        $display("%-10s %s a=%h b=%h busy=%0d -> %h (expect %h)", nm, is_div ? "div" : "mul",
                 a, b, n, ALUResult, exp);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0]  = '{"add_ovf",  4'b0010, 32'h7FFF_FFFF, 32'h0000_0001, 5'd0,  32'h8000_0000};
        vecs[1]  = '{"sub_zero", 4'b0110, 32'd5,         32'd5,         5'd0,  32'h0000_0000};
        vecs[2]  = '{"sra",      4'b1010, 32'h0,         32'h8000_0000, 5'd4,  32'hF800_0000};
        vecs[3]  = '{"slt_t",    4'b0111, 32'hFFFF_FFFF, 32'd1,         5'd0,  32'h0000_0001};
        vecs[4]  = '{"slt_f",    4'b0111, 32'd1,         32'hFFFF_FFFF, 5'd0,  32'h0000_0000};
        vecs[5]  = '{"undef_f",  4'b1111, 32'h1234_5678, 32'h9ABC_DEF0, 5'd3,  32'h0000_0000};
        vecs[6]  = '{"and",      4'b0000, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0,  32'hF000_F000};
        vecs[7]  = '{"or",       4'b0001, 32'h0F0F_0000, 32'h0000_00F0, 5'd0,  32'h0F0F_00F0};
        vecs[8]  = '{"nor",      4'b1100, 32'h0,         32'h0,         5'd0,  32'hFFFF_FFFF};
        vecs[9]  = '{"sll",      4'b1000, 32'h0,         32'h0000_0001, 5'd31, 32'h8000_0000};
        vecs[10] = '{"srl",      4'b1001, 32'h0,         32'h8000_0000, 5'd31, 32'h0000_0001};
        vecs[11] = '{"add_wrap", 4'b0010, 32'hFFFF_FFFF, 32'h0000_0001, 5'd0,  32'h0000_0000};
        vecs[12] = '{"xor",      4'b0100, 32'hAAAA_AAAA, 32'hFFFF_FFFF, 5'd0,  32'h5555_5555};

        Reset = 1'b1; In_Valid = 1'b0; Flush = 1'b0;
        ALU_Control = 4'b0; A = '0; B = '0; Shamt = '0;
        last_res = 32'd0;
        repeat (2) @(posedge Clk);
        #1;
        check("rst.busy",   32'(Busy),      32'd0);
        check("rst.valid",  32'(Out_Valid), 32'd0);
        check("rst.result", ALUResult,      32'd0);
        check("rst.zero",   32'(Zero),      32'd1);
        Reset = 1'b0;
        @(posedge Clk); #1;

        for (int i = 0; i < 13; i++)
            apply_single(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].sh, vecs[i].exp);

        // Reset between edges must clear outputs without waiting for Clk.
        Reset = 1'b1;
        #1;
        check("arst.valid",  32'(Out_Valid), 32'd0);
        check("arst.result", ALUResult,      32'd0);
        check("arst.zero",   32'(Zero),      32'd1);
        #1;
        Reset = 1'b0;
        last_res = 32'd0;

        apply_single("pre_idle", 4'b0010, 32'd40, 32'd2, 5'd0, 32'd42);
        @(posedge Clk); #1;
        check("idle.valid",  32'(Out_Valid), 32'd0);
        check("idle.result", ALUResult,      last_res);

        ALU_Control = 4'b0010; A = 32'd2; B = 32'd2; In_Valid = 1'b1; Flush = 1'b1;
        @(posedge Clk); #1;
        In_Valid = 1'b0; Flush = 1'b0;
        check("flush1.valid",  32'(Out_Valid), 32'd0);
        check("flush1.result", ALUResult,      last_res);
        $display("flush     single-cycle add dropped, result %h", ALUResult);

        for (int i = 0; i < 80; i++) begin
            logic [3:0]  op;
            logic [31:0] a, b;
            logic [4:0]  sh;
            op = 4'($urandom_range(0, 15));
`ifdef ALU_MULDIV_EN
            if (op == 4'b0101 || op == 4'b1011) op = 4'b0110;
`endif
            a  = $urandom;
            b  = (i % 7 == 0) ? a : $urandom;
            sh = 5'($urandom_range(0, 31));
            apply_single("rand", op, a, b, sh, ref_single(op, a, b, sh));
        end

`ifdef ALU_MULDIV_EN
        run_long("mul_m3x7", 1'b0, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFEB, 1'b1);
        @(posedge Clk); #1;
        check("mul.ignored_valid",  32'(Out_Valid), 32'd0);
        check("mul.ignored_result", ALUResult,      32'hFFFF_FFEB);

        run_long("div_m7d2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0);
        apply_single("b2b_add", 4'b0010, 32'd3, 32'd4, 5'd0, 32'd7);
        run_long("div_by0", 1'b1, 32'd1234, 32'd0, 32'hFFFF_FFFF, 1'b0);
        run_long("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0);
        run_long("mul_zero", 1'b0, 32'd0, 32'hDEAD_BEEF, 32'd0, 1'b0);

        begin
            int hits = 0;
            ALU_Control = 4'b1011; A = 32'd100; B = 32'd3; In_Valid = 1'b1;
            @(posedge Clk); #1;
            In_Valid = 1'b0;
            repeat (4) @(posedge Clk);
            #1;
            check("flush.busy_before", 32'(Busy), 32'd1);
            Flush = 1'b1; In_Valid = 1'b1; ALU_Control = 4'b0010; A = 32'd9; B = 32'd9;
            @(posedge Clk); #1;
            Flush = 1'b0; In_Valid = 1'b0;
            check("flush.busy",   32'(Busy),      32'd0);
            check("flush.valid",  32'(Out_Valid), 32'd0);
            check("flush.result", ALUResult,      last_res);
            for (int c = 0; c < 40; c++) begin
                @(posedge Clk); #1;
                if (Out_Valid) hits++;
            end
            check("flush.no_valid", 32'(hits), 32'd0);
            $display("flush     div aborted in cycle 5, add dropped, result %h", ALUResult);
            apply_single("post_flush", 4'b0010, 32'd2, 32'd3, 5'd0, 32'd5);
        end

        begin
            int hits = 0;
            ALU_Control = 4'b0101; A = 32'd12345; B = 32'd678; In_Valid = 1'b1;
            @(posedge Clk); #1;
            In_Valid = 1'b0;
            repeat (9) @(posedge Clk);
            #1;
            check("rstmul.busy_before", 32'(Busy), 32'd1);
            Reset = 1'b1;
            #1;
            check("rstmul.busy",   32'(Busy),      32'd0);
            check("rstmul.result", ALUResult,      32'd0);
            check("rstmul.zero",   32'(Zero),      32'd1);
            #1;
            Reset = 1'b0;
            last_res = 32'd0;
            for (int c = 0; c < 40; c++) begin
                @(posedge Clk); #1;
                if (Out_Valid) hits++;
            end
            check("rstmul.no_valid", 32'(hits), 32'd0);
            check("rstmul.held",     ALUResult, 32'd0);
            $display("rstmul    reset 10 cycles into mul, busy=%0d result %h", Busy, ALUResult);
        end

        for (int i = 0; i < 30; i++) begin
            bit          is_div;
            logic [31:0] a, b;
            is_div = (i % 2 == 1);
            a = $urandom;
            if (i % 5 == 0)      b = 32'd0;
            else if (i % 3 == 0) b = $urandom;
            else                 b = 32'($urandom_range(1, 999)) * (($urandom_range(0, 1) == 1) ? -1 : 1);
            run_long(is_div ? "rand_div" : "rand_mul", is_div, a, b, ref_long(is_div, a, b), 1'b0);
        end
`else
        apply_single("mul_undef", 4'b0101, 32'hFFFF_FFFD, 32'd7, 5'd0, 32'd0);
        check("mul_undef.busy", 32'(Busy), 32'd0);
        apply_single("div_undef", 4'b1011, 32'hFFFF_FFF9, 32'd2, 5'd0, 32'd0);
        check("div_undef.busy", 32'(Busy), 32'd0);
        apply_single("after_md", 4'b0010, 32'd2, 32'd3, 5'd0, 32'd5);
`endif

        @(posedge Clk); #1;
        check("final.valid",  32'(Out_Valid), 32'd0);
        check("final.result", ALUResult,      last_res);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
